// File: rtl/brisc_pkg.sv
// Shared types and constants for the decode stage.
package brisc_pkg;

    localparam int XLEN    = 32;
    localparam int ILEN    = 32;
    localparam int REG_LEN = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        ITYPE_R = 3'd0,
        ITYPE_I = 3'd1,
        ITYPE_S = 3'd2,
        ITYPE_B = 3'd3,
        ITYPE_U = 3'd4,
        ITYPE_J = 3'd5
    } itype_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [REG_LEN-1:0] rs1;
        logic [REG_LEN-1:0] rs2;
        logic [REG_LEN-1:0] rd;
        logic [XLEN-1:0]    imm;
        itype_e             itype;
        logic               rs1_used;
        logic               rs2_used;
        logic               rd_we;
        logic               illegal;
    } decoded_t;

endpackage

// File: rtl/decode_imm.sv
// Immediate generator: assembles the sign-extended immediate for a format.
module decode_imm
    import brisc_pkg::*;
(
    input  logic [ILEN-1:0] instr,
    input  itype_e          itype,
    output logic [XLEN-1:0] imm
);

    // The opcode bits never contribute to an immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Bit scatter per format; sign always comes from instr[31].
    always_comb begin
        imm = '0;
        case (itype)
            ITYPE_I: imm = {{20{instr[31]}}, instr[31:20]};
            ITYPE_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            ITYPE_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            ITYPE_U: imm = {instr[31:12], 12'b0};
            ITYPE_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage with valid/ready handshake and flush.
// Optional skid entry enabled by defining DECODE_STAGE_SKID_EN; this makes
// in_ready a registered "skid empty" flag while keeping full throughput.
module decode_stage
    import brisc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ILEN-1:0]    in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [6:0]         out_opcode,
    output logic [2:0]         out_funct3,
    output logic [6:0]         out_funct7,
    output logic [REG_LEN-1:0] out_rs1,
    output logic [REG_LEN-1:0] out_rs2,
    output logic [REG_LEN-1:0] out_rd,
    output logic [XLEN-1:0]    out_imm,
    output itype_e             out_itype,
    output logic               out_rs1_used,
    output logic               out_rs2_used,
    output logic               out_rd_we,
    output logic               out_illegal
);

    itype_e          itype_c;
    logic            legal_c;
    logic [XLEN-1:0] imm_c;
    decoded_t        dec;
    decoded_t        out_q;
    logic            out_valid_q;
    logic            accept;
    logic            consume;

    // Format and legality from the opcode; illegal words decode as R with no side effects.
    always_comb begin
        itype_c = ITYPE_R;
        legal_c = 1'b1;
        case (in_instr[6:0])
            OPC_LUI, OPC_AUIPC:  itype_c = ITYPE_U;
            OPC_JAL:             itype_c = ITYPE_J;
            OPC_JALR: begin
                itype_c = ITYPE_I;
                legal_c = (in_instr[14:12] == 3'b000);
            end
            OPC_LOAD, OPC_OPIMM: itype_c = ITYPE_I;
            OPC_STORE:           itype_c = ITYPE_S;
            OPC_BRANCH:          itype_c = ITYPE_B;
            OPC_OP: begin
                itype_c = ITYPE_R;
                legal_c = (in_instr[31:25] == 7'h00) ||
                          ((in_instr[31:25] == 7'h20) &&
                           ((in_instr[14:12] == 3'b000) || (in_instr[14:12] == 3'b101)));
            end
            default: legal_c = 1'b0;
        endcase
        if (!legal_c) begin
            itype_c = ITYPE_R;
        end
    end

    decode_imm u_imm (
        .instr (in_instr),
        .itype (itype_c),
        .imm   (imm_c)
    );

    // Assemble the payload; register fields are zeroed whenever their use flag is clear.
    always_comb begin
        dec          = '0;
        dec.pc       = in_pc;
        dec.opcode   = in_instr[6:0];
        dec.funct3   = in_instr[14:12];
        dec.funct7   = in_instr[31:25];
        dec.itype    = itype_c;
        dec.illegal  = !legal_c;
        dec.imm      = legal_c ? imm_c : '0;
        dec.rs1_used = legal_c && (itype_c inside {ITYPE_R, ITYPE_I, ITYPE_S, ITYPE_B});
        dec.rs2_used = legal_c && (itype_c inside {ITYPE_R, ITYPE_S, ITYPE_B});
        dec.rd_we    = legal_c && (itype_c inside {ITYPE_R, ITYPE_I, ITYPE_U, ITYPE_J}) &&
                       (in_instr[11:7] != 5'd0);
        dec.rs1      = dec.rs1_used ? in_instr[19:15] : '0;
        dec.rs2      = dec.rs2_used ? in_instr[24:20] : '0;
        dec.rd       = dec.rd_we    ? in_instr[11:7]  : '0;
    end

    assign consume = out_valid_q && out_ready;
    assign accept  = in_valid && in_ready && !flush;

`ifdef DECODE_STAGE_SKID_EN
    decoded_t skid_q;
    logic     skid_valid_q;
    logic     in_ready_q;

    assign in_ready = in_ready_q;

    // Output register plus skid entry; skid only fills while the output is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (!out_valid_q || consume) begin
            // in_ready is low while skid is full, so accept and skid_valid never coincide.
            if (skid_valid_q) begin
                out_q        <= skid_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end else if (accept) begin
                out_q       <= dec;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= dec;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
        end
    end
`else
    assign in_ready = !out_valid_q || out_ready;

    // Single output register; a consume and an accept in one cycle swap entries with no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
        end else if (consume) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid    = out_valid_q;
    assign out_pc       = out_q.pc;
    assign out_opcode   = out_q.opcode;
    assign out_funct3   = out_q.funct3;
    assign out_funct7   = out_q.funct7;
    assign out_rs1      = out_q.rs1;
    assign out_rs2      = out_q.rs2;
    assign out_rd       = out_q.rd;
    assign out_imm      = out_q.imm;
    assign out_itype    = out_q.itype;
    assign out_rs1_used = out_q.rs1_used;
    assign out_rs2_used = out_q.rs2_used;
    assign out_rd_we    = out_q.rd_we;
    assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: queue-based reference of the stage contents plus
// an instruction-set level decoder, checked every cycle.
module tb_decode_stage;
    import brisc_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    itype_e      out_itype;
    logic        out_rs1_used, out_rs2_used, out_rd_we, out_illegal;

    int pass_cnt = 0;
    int total_cnt = 0;
    decoded_t q[$];
    decoded_t log_q[$];
    logic last_acc = 1'b0;
    logic [6:0] ops [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h23, 7'h63, 7'h33};

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_itype(out_itype), .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used),
        .out_rd_we(out_rd_we), .out_illegal(out_illegal)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Instruction-set view of a word: format table, then immediate by signed arithmetic.
    function automatic decoded_t ref_dec(input logic [31:0] w, input logic [31:0] pc);
        decoded_t d;
        itype_e   f;
        bit       ok;
        int       v;
        d = '0;
        ok = 1;
        f = ITYPE_R;
        case (w[6:0])
            7'h37, 7'h17: f = ITYPE_U;
            7'h6F:        f = ITYPE_J;
            7'h67: begin f = ITYPE_I; ok = (w[14:12] == 0); end
            7'h03, 7'h13: f = ITYPE_I;
            7'h23:        f = ITYPE_S;
            7'h63:        f = ITYPE_B;
            7'h33: ok = (w[31:25] == 0) || (w[31:25] == 7'h20 && (w[14:12] == 0 || w[14:12] == 5));
            default: ok = 0;
        endcase
        if (!ok) f = ITYPE_R;
        v = 0;
        if (ok) begin
            case (f)
                ITYPE_I: v = $signed(w[31:20]);
                ITYPE_S: v = $signed({w[31:25], w[11:7]});
                ITYPE_B: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
                ITYPE_U: v = w[31:12] * 4096;
                ITYPE_J: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
                default: v = 0;
            endcase
        end
        d.pc = pc;
        d.opcode = w[6:0];
        d.funct3 = w[14:12];
        d.funct7 = w[31:25];
        d.imm = v;
        d.itype = f;
        d.illegal = !ok;
        d.rs1_used = ok && f != ITYPE_U && f != ITYPE_J;
        d.rs2_used = ok && (f == ITYPE_R || f == ITYPE_S || f == ITYPE_B);
        d.rd_we = ok && f != ITYPE_S && f != ITYPE_B && w[11:7] != 0;
        d.rs1 = d.rs1_used ? w[19:15] : 5'd0;
        d.rs2 = d.rs2_used ? w[24:20] : 5'd0;
        d.rd = d.rd_we ? w[11:7] : 5'd0;
        return d;
    endfunction

    function automatic logic model_ready(input logic rdy);
`ifdef DECODE_STAGE_SKID_EN
        return q.size() < 2;
`else
        return q.size() == 0 || rdy;
`endif
    endfunction

    function automatic decoded_t dut_bundle();
        decoded_t d;
        d = '{out_pc, out_opcode, out_funct3, out_funct7, out_rs1, out_rs2, out_rd, out_imm,
              out_itype, out_rs1_used, out_rs2_used, out_rd_we, out_illegal};
        return d;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 11);
        if (k < 9) w[6:0] = ops[k];
        if (w[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
            w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
        if (w[6:0] == 7'h67 && $urandom_range(0, 1) != 0) w[14:12] = 3'b000;
        return w;
    endfunction

    // One clock cycle: drive after the falling edge, update reference at the rising edge, compare at next falling edge.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] p,
                        input logic rdy, input logic fl, input logic rs);
        logic mr;
        decoded_t got;
        in_valid = v; in_instr = ins; in_pc = p; out_ready = rdy; flush = fl; rst_n = rs;
        mr = model_ready(rdy);
        last_acc = 1'b0;
        #1;
        if (rs) chk("in_ready", in_ready, mr);
        @(posedge clk);
        if (!rs || fl) begin
            q.delete();
        end else begin
            last_acc = v && mr;
            if (q.size() > 0 && rdy) log_q.push_back(q.pop_front());
            if (last_acc) q.push_back(ref_dec(ins, p));
        end
        @(negedge clk);
        chk("out_valid", out_valid, q.size() > 0);
        got = dut_bundle();
        if (q.size() > 0) chk("payload", got, q[0]);
        else if (!rs) chk("reset_data", got, '0);
    endtask

    initial begin
        decoded_t m;
        int base, idx;
        logic [31:0] sw [4] = '{32'h00108093, 32'h00210113, 32'h003182B3, 32'h12345337};
        rst_n = 0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        @(negedge clk);

        // Pin the reference decoder with hand-computed values.
        m = ref_dec(32'hFFF10093, 0);
        chk("ref_addi_imm", m.imm, 32'hFFFFFFFF);
        chk("ref_addi_rs1", m.rs1, 5'd2);
        m = ref_dec(32'hFE208EE3, 0);
        chk("ref_beq_imm", m.imm, 32'hFFFFFFFC);
        m = ref_dec(32'h123452B7, 0);
        chk("ref_lui_imm", m.imm, 32'h12345000);
        m = ref_dec(32'h40209033, 0);
        chk("ref_r_illegal", m.illegal, 1'b1);

        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_imm", out_imm, 32'h0);
        step(0, 0, 0, 0, 0, 1);
        chk("rst_in_ready", in_ready, 1'b1);

        // Directed decodes streamed back to back.
        step(1, 32'hFFF10093, 32'h100, 1, 0, 1);
        chk("addi_itype", out_itype, ITYPE_I);
        chk("addi_rs1", out_rs1, 5'd2);
        chk("addi_rd", out_rd, 5'd1);
        chk("addi_imm", out_imm, 32'hFFFFFFFF);
        chk("addi_rd_we", out_rd_we, 1'b1);
        chk("addi_rs2_used", out_rs2_used, 1'b0);
        step(1, 32'hFE208EE3, 32'h104, 1, 0, 1);
        chk("beq_itype", out_itype, ITYPE_B);
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        chk("beq_rd_we", out_rd_we, 1'b0);
        chk("beq_rs1_used", out_rs1_used, 1'b1);
        chk("beq_rs2_used", out_rs2_used, 1'b1);
        step(1, 32'h00208033, 32'h108, 1, 0, 1);
        chk("add_x0_rd_we", out_rd_we, 1'b0);
        step(1, 32'h123452B7, 32'h10C, 1, 0, 1);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_rd_we", out_rd_we, 1'b1);
        step(1, 32'h00000000, 32'h110, 1, 0, 1);
        chk("zero_illegal", out_illegal, 1'b1);
        chk("zero_rd_we", out_rd_we, 1'b0);
        step(1, 32'h40209033, 32'h114, 1, 0, 1);
        chk("r20_illegal", out_illegal, 1'b1);
        chk("r20_rd_we", out_rd_we, 1'b0);
        step(0, 0, 0, 1, 0, 1);

        // Four instructions against a 3-cycle stall.
        base = log_q.size();
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            step(idx < 4, sw[idx % 4], 32'h200 + 4 * idx, c >= 3, 0, 1);
            if (last_acc) idx++;
        end
        chk("stream_count", log_q.size() - base, 4);
        for (int j = 0; j < 4 && base + j < log_q.size(); j++)
            chk("stream_order", log_q[base + j].pc, 32'h200 + 4 * j);

        // Flush while stalled with a new instruction offered.
        step(1, 32'hFFF10093, 32'h300, 0, 0, 1);
        step(1, 32'h00210113, 32'h304, 0, 0, 1);
        base = log_q.size();
        step(1, 32'h123452B7, 32'h308, 0, 1, 1);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b1);
        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        chk("flush_no_present", log_q.size() - base, 0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 29) == 0, $urandom_range(0, 199) != 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered instruction-decode stage sitting between fetch and register read. Unlike the earlier combinational decoder, it derives the instruction format from the opcode itself and covers all base formats (R/I/S/B/U/J). It produces sign-extended XLEN-bit immediates, register-use flags and an illegal-instruction flag. It presents results through a valid/ready handshake with flush, with an optional skid buffer for full throughput under a registered `in_ready`.

## Interface
- `XLEN`, 32, width of `in_pc`, `out_pc` and `out_imm`.
- `clk` in 1 — single clock, all state on rising edge.
- `rst_n` in 1 — synchronous, active-low reset.
- `flush` in 1 — discard all held entries.
- `in_valid` in 1 — fetch presents an instruction.
- `in_ready` out 1 — stage accepts on `in_valid && in_ready`.
- `in_instr` in 32 — raw instruction word.
- `in_pc` in XLEN — instruction address.
- `out_valid` out 1 — decoded entry available.
- `out_ready` in 1 — downstream consumes on `out_valid && out_ready`.
- `out_pc` out XLEN — address of the presented entry.
- `out_opcode` out 7.
- `out_funct3` out 3.
- `out_funct7` out 7.
- `out_rs1`, `out_rs2`, `out_rd` out 5 each.
- `out_imm` out XLEN — sign-extended immediate.
- `out_itype` out `itype_e` — R/I/S/B/U/J.
- `out_rs1_used`, `out_rs2_used`, `out_rd_we` out 1 each.
- `out_illegal` out 1.

## Operation
- Format from `instr[6:0]`:
  - LUI 0110111 and AUIPC 0010111 → U.
  - JAL 1101111 → J.
  - JALR 1100111, LOAD 0000011 and OP-IMM 0010011 → I.
  - STORE 0100011 → S.
  - BRANCH 1100011 → B.
  - OP 0110011 → R.
- Illegal cases:
  - Any other opcode.
  - `instr[1:0]!=2'b11`.
  - R-type with `funct7` not in {0x00,0x20}.
  - R-type with `funct7`=0x20 and `funct3` not in {000,101}.
  - JALR with `funct3!=0`.
- Immediates are sign-extended from bit 31:
  - I: `instr[31:20]`.
  - S: {`[31:25]`,`[11:7]`}.
  - B: {`[31]`,`[7]`,`[30:25]`,`[11:8]`,0}.
  - U: {`[31:12]`,12'b0}, no extension beyond XLEN=32.
  - J: {`[31]`,`[19:12]`,`[20]`,`[30:21]`,0}.
  - R: 0.
- Register fields and flags:
  - `rs1`/`rs2`/`rd` are extracted by bit position always; unused fields are forced to 0.
  - `rs1_used`: R, I, S, B.
  - `rs2_used`: R, S, B.
  - `rd_we`: R, I, U, J and `rd!=0`.
- Illegal entries: still passed downstream with `out_illegal=1`. `rd_we`, `rs1_used` and `rs2_used` are forced 0, `out_itype=R` and `out_imm=0`.
- Decode is combinational on `in_instr`; results are captured into the output register on accept.

## Timing
- Latency: 1 cycle, from accept to `out_valid`.
- Reset (`rst_n=0` at edge):
  - `out_valid=0` and all `out_*` data are 0.
  - The skid entry is emptied.
  - `in_ready` is 1 the cycle after reset deasserts.
- Handshake:
  - `out_*` stable while `out_valid && !out_ready`.
  - `out_valid` never drops without a consume or a flush.
- `flush` at an edge:
  - Both entries are invalidated.
  - An instruction offered in the same cycle is dropped, not accepted. Flush wins over accept.
  - `out_valid=0` next cycle.
- Simultaneous consume and accept: new entry replaces output with no bubble, so throughput is 1 per cycle.
- `rst_n` low mid-transfer: the entry is lost; no partial state survives.

## Configuration
- `DECODE_STAGE_SKID_EN` defined:
  - Adds a second entry (skid register) and makes `in_ready` a flop equal to "skid empty".
  - When the output stalls, an accepted entry lands in skid. On the next consume, skid moves to output.
  - Order is preserved.
- Not defined:
  - Single output register.
  - `in_ready = !out_valid || out_ready`, combinational from `out_ready`.
- Functional ordering and latency are identical in both builds.

## Structure
- `brisc_pkg` holds:
  - `itype_e` extended with U and J.
  - `OPC_LUI`, `OPC_AUIPC`, `OPC_JAL`, `OPC_JALR`, `OPC_BRANCH`, `OPC_LOAD`, `OPC_STORE`, `OPC_OPIMM`, `OPC_OP`.
  - `ILEN`, `REG_LEN`.
  - A packed `decoded_t` struct holding all `out_*` payload fields.
- One combinational sub-module `decode_imm`: inputs instr and itype, output XLEN immediate. The top holds the handshake and registers.

## Test plan
- ADDI x1,x2,-1 (0xFFF10093) → next cycle: `itype=I`, `rs1=2`, `rd=1`, `imm=0xFFFFFFFF`, `rd_we=1`, `rs2_used=0`.
- BEQ x1,x2,-4 (0xFE208EE3) → `itype=B`, `imm=0xFFFFFFFC`, `rd_we=0`, `rs1_used=1`, `rs2_used=1`.
- ADD with `rd=x0`; LUI x5,0x12345 → first gives `rd_we=0`; second gives `imm=0x12345000`, `rd_we=1`.
- Word 0x00000000 and R-type with `funct7`=0x20 and `funct3`=001 → `out_illegal=1`, `rd_we=0`.
- Stream 4 instrs, hold `out_ready=0` for 3 cycles, then 1 → no loss or duplication, order kept. With `DECODE_STAGE_SKID_EN`: `in_ready` drops only after 2 held entries.
- `flush` asserted with `in_valid=1` while output stalled → `out_valid=0` next cycle, the offered instr is never presented, and `in_ready=1`.
